// File: rtl/controlador_cajero_if.sv
// Bus between the cashier stimulus stage (master) and the transaction controller (slave).
interface controlador_cajero_if #(
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
);
    logic                     tarjeta_recibida;
    logic                     tipo_trans;
    logic                     digito_stb;
    logic [3:0]               digito;
    logic [15:0]              pin;
    logic [ANCHO_BALANCE-1:0] balance_inicial;
    logic [ANCHO_MONTO-1:0]   monto;
    logic                     monto_stb;
    logic [ANCHO_BALANCE-1:0] balance;
    logic                     balance_actualizado;
    logic                     entregar_dinero;
    logic                     pin_incorrecto;
    logic                     advertencia;
    logic                     bloqueo;
    logic                     fondos_insuficientes;

    modport master (
        output tarjeta_recibida, tipo_trans, digito_stb, digito, pin,
               balance_inicial, monto, monto_stb,
        input  balance, balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );

    modport slave (
        input  tarjeta_recibida, tipo_trans, digito_stb, digito, pin,
               balance_inicial, monto, monto_stb,
        output balance, balance_actualizado, entregar_dinero, pin_incorrecto,
               advertencia, bloqueo, fondos_insuficientes
    );
endinterface

// File: rtl/controlador_cajero.sv
// Cashier transaction controller: PIN check with attempt lockout, then one
// deposit (saturating) or withdrawal (funds-checked) against the balance.
module controlador_cajero #(
    parameter int INTENTOS_MAX  = 3,
    parameter int ANCHO_BALANCE = 64,
    parameter int ANCHO_MONTO   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    controlador_cajero_if.slave  bus
);
    localparam int ANCHO_FALLOS = $clog2(INTENTOS_MAX + 1);

    typedef enum logic [2:0] {
        ESPERA_TARJETA,
        INGRESO_PIN,
        VALIDAR,
        ESPERA_MONTO,
        EJECUTAR,
        FIN,
        BLOQUEO
    } estado_t;

    estado_t                  estado;
    logic [15:0]              digitos;
    logic [1:0]               cuenta;
    logic [ANCHO_FALLOS-1:0]  fallos;
    logic [ANCHO_FALLOS-1:0]  fallos_sig;
    logic [ANCHO_MONTO-1:0]   monto_reg;
    logic                     tipo_reg;
    logic [ANCHO_BALANCE-1:0] monto_ext;

    // Sum computed one bit wider; a carry out clamps to all ones.
    function automatic logic [ANCHO_BALANCE-1:0] suma_sat(
        input logic [ANCHO_BALANCE-1:0] a,
        input logic [ANCHO_BALANCE-1:0] b
    );
        logic [ANCHO_BALANCE:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ANCHO_BALANCE] ? '1 : s[ANCHO_BALANCE-1:0];
    endfunction

    assign fallos_sig = fallos + ANCHO_FALLOS'(1);
    assign monto_ext  = {{(ANCHO_BALANCE - ANCHO_MONTO){1'b0}}, monto_reg};

    always_ff @(posedge clock) begin
        if (reset) begin
            estado                   <= ESPERA_TARJETA;
            digitos                  <= '0;
            cuenta                   <= '0;
            fallos                   <= '0;
            monto_reg                <= '0;
            tipo_reg                 <= 1'b0;
            bus.balance              <= '0;
            bus.balance_actualizado  <= 1'b0;
            bus.entregar_dinero      <= 1'b0;
            bus.pin_incorrecto       <= 1'b0;
            bus.advertencia          <= 1'b0;
            bus.bloqueo              <= 1'b0;
            bus.fondos_insuficientes <= 1'b0;
        end else begin
            bus.balance_actualizado  <= 1'b0;
            bus.entregar_dinero      <= 1'b0;
            bus.pin_incorrecto       <= 1'b0;
            bus.fondos_insuficientes <= 1'b0;
            case (estado)
                ESPERA_TARJETA: begin
                    if (bus.tarjeta_recibida) begin
                        bus.balance <= bus.balance_inicial;
                        cuenta      <= '0;
                        digitos     <= '0;
                        monto_reg   <= '0;
                        tipo_reg    <= 1'b0;
                        estado      <= INGRESO_PIN;
                    end
                end
                INGRESO_PIN: begin
                    if (!bus.tarjeta_recibida) begin
                        cuenta  <= '0;
                        digitos <= '0;
                        estado  <= ESPERA_TARJETA;
                    end else if (bus.digito_stb) begin
                        digitos <= {digitos[11:0], bus.digito};
                        cuenta  <= cuenta + 2'd1;
                        if (cuenta == 2'd3) begin
                            estado <= VALIDAR;
                        end
                    end
                end
                VALIDAR: begin
                    cuenta <= '0;
                    if (!bus.tarjeta_recibida) begin
                        estado <= ESPERA_TARJETA;
                    end else if (digitos == bus.pin) begin
                        fallos          <= '0;
                        bus.advertencia <= 1'b0;
                        estado          <= ESPERA_MONTO;
                    end else begin
                        bus.pin_incorrecto <= 1'b1;
                        fallos             <= fallos_sig;
                        if (fallos_sig == ANCHO_FALLOS'(INTENTOS_MAX)) begin
                            bus.bloqueo     <= 1'b1;
                            bus.advertencia <= 1'b0;
                            estado          <= BLOQUEO;
                        end else begin
                            if (fallos_sig == ANCHO_FALLOS'(INTENTOS_MAX - 1)) begin
                                bus.advertencia <= 1'b1;
                            end
                            estado <= INGRESO_PIN;
                        end
                    end
                end
                ESPERA_MONTO: begin
                    if (!bus.tarjeta_recibida) begin
                        estado <= ESPERA_TARJETA;
                    end else if (bus.monto_stb) begin
                        monto_reg <= bus.monto;
                        tipo_reg  <= bus.tipo_trans;
                        estado    <= EJECUTAR;
                    end
                end
                EJECUTAR: begin
                    if (!bus.tarjeta_recibida) begin
                        estado <= ESPERA_TARJETA;
                    end else if (!tipo_reg) begin
                        bus.balance             <= suma_sat(bus.balance, monto_ext);
                        bus.balance_actualizado <= 1'b1;
                        estado                  <= FIN;
                    end else if (monto_ext <= bus.balance) begin
                        bus.balance             <= bus.balance - monto_ext;
                        bus.balance_actualizado <= 1'b1;
                        bus.entregar_dinero     <= 1'b1;
                        estado                  <= FIN;
                    end else begin
                        bus.fondos_insuficientes <= 1'b1;
                        estado                   <= ESPERA_MONTO;
                    end
                end
                FIN: begin
                    if (!bus.tarjeta_recibida) begin
                        estado <= ESPERA_TARJETA;
                    end
                end
                BLOQUEO: begin
                    estado <= BLOQUEO;
                end
                default: begin
                    estado <= ESPERA_TARJETA;
                end
            endcase
        end
    end
endmodule

// File: doc/controlador_cajero.md
# controlador_cajero

- Transaction controller of the automatic cashier.
- Consumes the card, PIN-digit, amount and initial-balance stimulus driven by the bench stage upstream, and produces the status strobes that stage checks.
- Validates a 4-digit PIN with a 3-attempt lockout, then executes one deposit or withdrawal against a 64-bit balance.

## Interface
Parameters:
- INTENTOS_MAX, 3, wrong-PIN attempts that cause lockout
- ANCHO_BALANCE, 64, balance width
- ANCHO_MONTO, 32, amount width

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous active-high reset
- tarjeta_recibida  input  1  card present (level)
- tipo_trans  input  1  0 = deposit, 1 = withdrawal; sampled with monto_stb
- digito_stb  input  1  one digit valid this cycle
- digito  input  4  PIN digit, raw nibble
- pin  input  16  stored PIN; first entered digit compares to pin[15:12], last to pin[3:0]
- balance_inicial  input  64  account balance; loaded at card insertion
- monto  input  32  transaction amount
- monto_stb  input  1  monto/tipo_trans valid this cycle
- balance  output  64  current balance register
- balance_actualizado  output  1  one-cycle pulse: balance changed
- entregar_dinero  output  1  one-cycle pulse: dispense cash
- pin_incorrecto  output  1  one-cycle pulse: wrong PIN
- advertencia  output  1  level: one attempt left
- bloqueo  output  1  level: card locked, sticky until reset
- fondos_insuficientes  output  1  one-cycle pulse: withdrawal refused

## Operation
- States:
  - ESPERA_TARJETA: rising tarjeta_recibida loads balance ← balance_inicial, clears digit count → INGRESO_PIN.
  - INGRESO_PIN: each cycle with digito_stb=1 shifts digito into a 16-bit shift register (first digit ends in [15:12]) and increments a 2-bit digit count. 4th digit → VALIDAR.
  - VALIDAR:
    - Match: clear failure counter and advertencia → ESPERA_MONTO.
    - Mismatch: pulse pin_incorrecto, failure counter +1.
      - Counter = INTENTOS_MAX−1: set advertencia → INGRESO_PIN.
      - Counter = INTENTOS_MAX: set bloqueo, clear advertencia → BLOQUEO.
      - Otherwise → INGRESO_PIN.
    - Digit count always clears.
  - ESPERA_MONTO: monto_stb=1 captures monto and tipo_trans → EJECUTAR.
  - EJECUTAR:
    - Deposit: balance ← balance + monto, saturating at 2^64−1; pulse balance_actualizado → FIN.
    - Withdrawal, monto ≤ balance: balance ← balance − monto; pulse balance_actualizado and entregar_dinero together → FIN.
    - Withdrawal, monto > balance: pulse fondos_insuficientes, balance unchanged → ESPERA_MONTO (retry allowed).
  - FIN: wait for tarjeta_recibida=0 → ESPERA_TARJETA.
  - BLOQUEO: absorbing; all inputs ignored; exit only by reset.
- Card removal (tarjeta_recibida=0) in INGRESO_PIN, VALIDAR, ESPERA_MONTO or EJECUTAR:
  - Abort → ESPERA_TARJETA, discard partial digits and any captured amount, no pulses.
  - Failure counter and advertencia are kept, so lockout counts across cards until a correct PIN or reset.
- digito_stb outside INGRESO_PIN and monto_stb outside ESPERA_MONTO are ignored.
- Digit values above 9 are accepted and compared raw.
- Arithmetic:
  - monto is zero-extended to 64 bits.
  - Deposit sum is computed at 65 bits; a carry forces all ones.
  - Withdrawal with monto = balance is legal and yields 0.
  - monto = 0 is legal: balance is unchanged but balance_actualizado still pulses.

## Timing
- Reset, sampled at a rising edge:
  - State ← ESPERA_TARJETA.
  - All outputs 0, including balance.
  - Failure counter, digit count and shift register ← 0.
  - Reset wins over every simultaneous event, in any state.
- Insertion: tarjeta_recibida first sampled 1 at edge t → balance valid and state INGRESO_PIN from edge t.
- PIN: 4th digito_stb sampled at edge k → VALIDAR at k. Result registered at edge k+1: pin_incorrecto / advertencia / bloqueo change there, and the next state is entered at k+1.
- A digito_stb in the VALIDAR cycle is ignored.
- Amount: monto_stb sampled at edge m → EJECUTAR at m. At edge m+1, balance and all strobes update together; strobes are high for exactly cycle [m+1, m+2).
- All outputs are registered; no combinational input-to-output paths.
- Card removal and a strobe in the same cycle: removal wins.

## Test plan
- **Deposit:** reset 2 cycles; card in, balance_inicial=1000, pin=16'h1234; digits 1,2,3,4; monto_stb with monto=500, tipo_trans=0 → balance=1500, balance_actualizado one pulse at m+1, entregar_dinero stays 0.
- **Withdrawal:** balance 1000, withdraw 400 → balance=600 with balance_actualizado and entregar_dinero in the same cycle. Then remove the card → ESPERA_TARJETA.
- **Insufficient funds:** balance 300, withdraw 301 → fondos_insuficientes single pulse, balance=300, no dispense. Retry withdrawal of 300 → balance=0, entregar_dinero pulse.
- **Lockout:** enter 1,2,3,5 three times:
  - pin_incorrecto pulses on each attempt.
  - advertencia rises after the 2nd attempt.
  - bloqueo=1 and advertencia=0 after the 3rd.
  - Subsequent correct PIN and monto_stb produce no response until reset.
- **Counter clear:** two wrong PINs then the correct PIN → advertencia clears. Remove card, re-insert, one wrong PIN → no advertencia, no bloqueo.
- **Boundary:** balance_inicial=64'hFFFF_FFFF_FFFF_FF00, deposit 32'h200 → balance saturates to all ones. Separately, remove the card after 2 digits, re-insert, enter 4 correct digits → accepted.
